// File: rtl/gnrl_ltch_wctl.sv
// gnrl_ltch_wctl: write controller for a bank of DP latches sharing one data bus.
// Each write or clear entry is a SETUP/OPEN/HOLD sequence. The data bus settles one
// cycle before the single enable pulse and is held one cycle after it. All outputs
// are registered except wr_rdy.
module gnrl_ltch_wctl #(
  parameter int DW = 32,
  parameter int DP = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_req,
  output logic          clr_done,
  output logic [DP-1:0] ltch_lden,
  output logic [DW-1:0] ltch_dnxt,
  output logic          err_addr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] OPEN  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // The extra bit lets DP == 2^AW be represented in the range compare.
  localparam logic [AW:0]   DP_EXT     = (AW+1)'(DP);
  localparam logic [AW-1:0] LAST_ENTRY = AW'(DP-1);

  logic [1:0]    state;
  logic          clr_mode;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] sel_addr;
  logic          sel_ok;
  logic [DP-1:0] sel_onehot;
  logic          wr_acc;

  // A pending clear blocks new writes, so clear wins over a simultaneous write.
  assign wr_rdy = (state == IDLE) && !clr_req && !rst;
  assign wr_acc = wr_vld && wr_rdy;

  // Decode the entry addressed by the current operation into a one-hot enable.
  always_comb begin
    sel_addr   = clr_mode ? clr_cnt : wr_addr_q;
    sel_ok     = ({1'b0, sel_addr} < DP_EXT);
    sel_onehot = '0;
    for (int i = 0; i < DP; i++) begin
      sel_onehot[i] = (32'(sel_addr) == i);
    end
  end

  // Sequencing FSM with registered outputs. The clear walks the entries with its own counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clr_mode  <= 1'b0;
      wr_addr_q <= '0;
      clr_cnt   <= '0;
      ltch_lden <= '0;
      ltch_dnxt <= '0;
      err_addr  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      ltch_lden <= '0;
      err_addr  <= 1'b0;
      clr_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state     <= SETUP;
            clr_mode  <= 1'b1;
            clr_cnt   <= '0;
            ltch_dnxt <= '0;
          end else if (wr_acc) begin
            state     <= SETUP;
            clr_mode  <= 1'b0;
            wr_addr_q <= wr_addr;
            ltch_dnxt <= wr_data;
          end
        end
        SETUP: begin
          state     <= OPEN;
          ltch_lden <= sel_onehot;
          err_addr  <= !clr_mode && !sel_ok;
        end
        OPEN: begin
          state    <= HOLD;
          clr_done <= clr_mode && (clr_cnt == LAST_ENTRY);
        end
        HOLD: begin
          if (clr_mode && (clr_cnt != LAST_ENTRY)) begin
            clr_cnt <= clr_cnt + 1'b1;
            state   <= SETUP;
          end else begin
            clr_mode <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnrl_ltch_wctl.sv
// tb_gnrl_ltch_wctl: scoreboard bench for gnrl_ltch_wctl.
// One instance uses DP=8 and a second uses DP=6 for the out-of-range writes.
module tb_gnrl_ltch_wctl;

  typedef struct {
    int          cyc;
    logic [7:0]  lden;
    logic [31:0] dnxt;
    logic        err;
    logic        done;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_vld, wr_rdy, clr_req, clr_done, err_addr;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data, ltch_dnxt;
  logic [7:0]  ltch_lden;

  logic        wr_vld6, wr_rdy6, clr_req6, clr_done6, err_addr6;
  logic [2:0]  wr_addr6;
  logic [31:0] wr_data6, ltch_dnxt6;
  logic [5:0]  ltch_lden6;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_acc = 0;
  logic mon_en = 1'b0;
  ev_t  exp_q[$];
  ev_t  exp_q6[$];

  always #5 clk = ~clk;

  // Cycle counter: during cycle C the value read between edges is C.
  always @(posedge clk) cyc <= cyc + 1;

  gnrl_ltch_wctl #(.DW(32), .DP(8), .AW(3)) u_dut (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .clr_done(clr_done),
    .ltch_lden(ltch_lden), .ltch_dnxt(ltch_dnxt), .err_addr(err_addr)
  );

  gnrl_ltch_wctl #(.DW(32), .DP(6), .AW(3)) u_dut6 (
    .clk(clk), .rst(rst), .wr_vld(wr_vld6), .wr_rdy(wr_rdy6), .wr_addr(wr_addr6),
    .wr_data(wr_data6), .clr_req(clr_req6), .clr_done(clr_done6),
    .ltch_lden(ltch_lden6), .ltch_dnxt(ltch_dnxt6), .err_addr(err_addr6)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Main DUT monitor: one-hot, bus stability and scoreboard pops on every output event.
  logic [31:0] prev_dnxt;
  logic        pend = 1'b0;
  logic [31:0] pend_val;
  ev_t         e_main;
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("lden_onehot", 64'(!$isunknown(ltch_lden) && ($countones(ltch_lden) <= 1)), 64'd1);
      if (pend) begin
        checkOutput("dnxt_after_pulse", ltch_dnxt, pend_val);
        pend = 1'b0;
      end
      if (ltch_lden != '0) begin
        checkOutput("dnxt_before_pulse", prev_dnxt, ltch_dnxt);
        if (!rst) begin
          pend     = 1'b1;
          pend_val = ltch_dnxt;
        end
      end
      if ((ltch_lden != '0) || err_addr || clr_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event at cyc %0d: lden=%h err=%b done=%b, expected no event",
                   cyc, ltch_lden, err_addr, clr_done);
        end else begin
          e_main = exp_q.pop_front();
          checkOutput("ev_cycle", cyc, e_main.cyc);
          checkOutput("ev_lden", ltch_lden, e_main.lden);
          checkOutput("ev_dnxt", ltch_dnxt, e_main.dnxt);
          checkOutput("ev_err", err_addr, e_main.err);
          checkOutput("ev_done", clr_done, e_main.done);
        end
      end
      prev_dnxt = ltch_dnxt;
    end
  end

  // DP=6 DUT monitor: one-hot and scoreboard pops.
  ev_t e6;
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("lden6_onehot", 64'(!$isunknown(ltch_lden6) && ($countones(ltch_lden6) <= 1)), 64'd1);
      if ((ltch_lden6 != '0) || err_addr6 || clr_done6) begin
        if (exp_q6.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event6 at cyc %0d: lden=%h err=%b done=%b, expected no event",
                   cyc, ltch_lden6, err_addr6, clr_done6);
        end else begin
          e6 = exp_q6.pop_front();
          checkOutput("ev6_cycle", cyc, e6.cyc);
          checkOutput("ev6_lden", {2'b00, ltch_lden6}, e6.lden);
          checkOutput("ev6_dnxt", ltch_dnxt6, e6.dnxt);
          checkOutput("ev6_err", err_addr6, e6.err);
          checkOutput("ev6_done", clr_done6, e6.done);
        end
      end
    end
  end

  // Issue a write (is_clr=0) or a clear with a simultaneous write (is_clr=1) on the DP=8 DUT.
  task automatic applyStimulus(input bit is_clr, input logic [2:0] addr, input logic [31:0] data);
    int  k;
    ev_t ev;
    wr_addr = addr;
    wr_data = data;
    wr_vld  = 1'b1;
    clr_req = is_clr;
    #1;
    k = 0;
    while (!is_clr && !wr_rdy && (k < 20)) begin
      @(posedge clk); #1;
      k++;
    end
    if (is_clr) begin
      checkOutput("rdy_low_during_clr", wr_rdy, 64'd0);
      for (int i = 0; i < 8; i++) begin
        ev.cyc = cyc + 2 + 3 * i; ev.lden = 8'd1 << i; ev.dnxt = 32'd0; ev.err = 1'b0; ev.done = 1'b0;
        exp_q.push_back(ev);
      end
      ev.cyc = cyc + 24; ev.lden = 8'd0; ev.dnxt = 32'd0; ev.err = 1'b0; ev.done = 1'b1;
      exp_q.push_back(ev);
      last_acc = cyc;
    end else if (!wr_rdy) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: wr_rdy stayed %b, expected 1 within 20 cycles", wr_rdy);
    end else begin
      ev.cyc = cyc + 2; ev.lden = 8'd1 << addr; ev.dnxt = data; ev.err = 1'b0; ev.done = 1'b0;
      exp_q.push_back(ev);
      last_acc = cyc;
    end
    @(posedge clk); #1;
    wr_vld  = 1'b0;
    clr_req = 1'b0;
  endtask

  // Issue a write on the DP=6 DUT; addresses 6 and 7 must flag err_addr instead of an enable.
  task automatic applyWrite6(input logic [2:0] addr, input logic [31:0] data);
    int  k;
    ev_t ev;
    wr_addr6 = addr;
    wr_data6 = data;
    wr_vld6  = 1'b1;
    #1;
    k = 0;
    while (!wr_rdy6 && (k < 20)) begin
      @(posedge clk); #1;
      k++;
    end
    if (!wr_rdy6) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept6_timeout: wr_rdy6 stayed %b, expected 1 within 20 cycles", wr_rdy6);
    end else begin
      ev.cyc  = cyc + 2;
      ev.lden = (addr < 3'd6) ? (8'd1 << addr) : 8'd0;
      ev.dnxt = data;
      ev.err  = (addr >= 3'd6);
      ev.done = 1'b0;
      exp_q6.push_back(ev);
    end
    @(posedge clk); #1;
    wr_vld6 = 1'b0;
  endtask

  task automatic waitIdle();
    int k = 0;
    while (!wr_rdy && (k < 60)) begin
      @(posedge clk); #1;
      k++;
    end
    if (!wr_rdy) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout: wr_rdy stayed %b, expected 1 within 60 cycles", wr_rdy);
    end
  endtask

  // Directed test sequence.
  initial begin
    int k;
    int acc0;
    int c0;
    rst = 1'b1;
    wr_vld = 1'b0; clr_req = 1'b0; wr_addr = '0; wr_data = '0;
    wr_vld6 = 1'b0; clr_req6 = 1'b0; wr_addr6 = '0; wr_data6 = '0;

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_lden", ltch_lden, 64'd0);
    checkOutput("rst_dnxt", ltch_dnxt, 64'd0);
    checkOutput("rst_err", err_addr, 64'd0);
    checkOutput("rst_done", clr_done, 64'd0);
    checkOutput("rst_rdy", wr_rdy, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    checkOutput("rdy_after_reset", wr_rdy, 64'd1);

    $display("[TB] single write addr 5");
    applyStimulus(1'b0, 3'd5, 32'hDEADBEEF);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("rdy_busy", wr_rdy, 64'd0);
      checkOutput("dnxt_hold", ltch_dnxt, 64'hDEADBEEF);
      @(posedge clk); #1;
    end
    checkOutput("rdy_at_n4", wr_rdy, 64'd1);
    checkOutput("rdy_cycle", cyc, last_acc + 4);

    $display("[TB] back-to-back writes addr 0 then 7");
    applyStimulus(1'b0, 3'd0, 32'h0000_1111);
    acc0 = last_acc;
    applyStimulus(1'b0, 3'd7, 32'h7777_0000);
    checkOutput("b2b_spacing", last_acc - acc0, 64'd4);

    $display("[TB] clear with simultaneous write");
    waitIdle();
    applyStimulus(1'b1, 3'd3, 32'h0000_0055);
    waitIdle();

    $display("[TB] reset during OPEN");
    applyStimulus(1'b0, 3'd2, 32'h1234_5678);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_open_lden", ltch_lden, 64'd0);
    checkOutput("rst_open_dnxt", ltch_dnxt, 64'd0);
    checkOutput("rst_open_rdy", wr_rdy, 64'd1);

    $display("[TB] reset during clear");
    waitIdle();
    c0 = cyc;
    clr_req = 1'b1;
    exp_q.push_back('{cyc: c0 + 2, lden: 8'h01, dnxt: 32'd0, err: 1'b0, done: 1'b0});
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("rst_clr_rdy", wr_rdy, 64'd1);

    $display("[TB] DP=6 range checks");
    applyWrite6(3'd6, 32'hA5A5_0006);
    applyWrite6(3'd5, 32'hA5A5_0005);
    applyWrite6(3'd7, 32'hA5A5_0007);

    k = 0;
    while (((exp_q.size() != 0) || (exp_q6.size() != 0)) && (k < 100)) begin
      @(posedge clk);
      k++;
    end
    repeat (10) @(posedge clk);
    #1;
    checkOutput("sb_drain", exp_q.size(), 64'd0);
    checkOutput("sb6_drain", exp_q6.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
